// File: rtl/cache_write_scheduler.sv
// Four-port write scheduler: round-robin arbitration into a shared FIFO that
// drains one registered write per cycle into a cache bank, with read-hazard lookup.
module cache_write_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              req_valid,
  input  logic [4*ADDR_WIDTH-1:0] req_addr,
  input  logic [4*DATA_WIDTH-1:0] req_data,
  output logic [3:0]              req_ready,
  output logic                    cache_write,
  output logic [ADDR_WIDTH-1:0]   cache_write_addr,
  output logic [DATA_WIDTH-1:0]   cache_write_data,
  input  logic                    cache_stall,
  input  logic [ADDR_WIDTH-1:0]   rd_check_addr,
  output logic                    rd_hazard,
  output logic [$clog2(DEPTH):0]  queue_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic                  cache_write_q;
  logic [ADDR_WIDTH-1:0] cache_write_addr_q;
  logic [DATA_WIDTH-1:0] cache_write_data_q;

  logic                  grant_found;
  logic [1:0]            grant_idx, cand;
  logic                  full, push, pop, hazard;
  logic [PTR_W-1:0]      offset;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [DATA_WIDTH-1:0] push_data;

  // Round-robin search starting at rr_ptr_q; the first valid port wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    grant_found = 1'b0;
    grant_idx   = rr_ptr_q;
    cand        = '0;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Reset forces the empty-queue view so nothing upstream sees a stale full flag.
  assign full      = (count_q == CNT_W'(DEPTH)) && !reset;
  assign req_ready = (grant_found && !full) ? (4'b0001 << grant_idx) : 4'b0000;
  assign push      = |(req_valid & req_ready);
  assign pop       = (count_q != '0) && !cache_stall;

  always_comb begin
    push_addr = '0;
    push_data = '0;
    for (int p = 0; p < 4; p++) begin
      if (grant_idx == 2'(p)) begin
        push_addr = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        push_data = req_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // An entry is occupied when its distance from head is below the count.
  always_comb begin
    hazard = 1'b0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - head_q;
      if (({1'b0, offset} < count_q) && (addr_mem_q[i] == rd_check_addr)) hazard = 1'b1;
    end
  end
  assign rd_hazard = hazard && !reset;

  always_comb begin
    head_d   = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d   = push ? tail_q + PTR_W'(1) : tail_q;
    rr_ptr_d = push ? grant_idx + 2'd1   : rr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: queue storage has no reset; occupancy is tracked by head/tail/count alone.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      addr_mem_q[tail_q] <= push_addr;
      data_mem_q[tail_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      head_q             <= '0;
      tail_q             <= '0;
      count_q            <= '0;
      rr_ptr_q           <= '0;
      cache_write_q      <= 1'b0;
      cache_write_addr_q <= '0;
      cache_write_data_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      rr_ptr_q      <= rr_ptr_d;
      cache_write_q <= pop;
      if (pop) begin
        cache_write_addr_q <= addr_mem_q[head_q];
        cache_write_data_q <= data_mem_q[head_q];
      end
    end
  end

  assign cache_write      = cache_write_q;
  assign cache_write_addr = cache_write_addr_q;
  assign cache_write_data = cache_write_data_q;
  assign queue_count      = count_q;

endmodule

// File: tb/tb_cache_write_scheduler.sv
// Randomized plus directed bench for cache_write_scheduler: a queue-based reference
// model predicts grants, occupancy and hazards; a monitor scoreboards issued writes.
module tb_cache_write_scheduler;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req_valid;
  logic [4*AW-1:0] req_addr;
  logic [4*DW-1:0] req_data;
  logic [3:0]    req_ready;
  logic          cache_write;
  logic [AW-1:0] cache_write_addr;
  logic [DW-1:0] cache_write_data;
  logic          cache_stall;
  logic [AW-1:0] rd_check_addr;
  logic          rd_hazard;
  logic [$clog2(DEPTH):0] queue_count;

  always #5 clk = ~clk;

  cache_write_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .cache_write(cache_write), .cache_write_addr(cache_write_addr),
    .cache_write_data(cache_write_data), .cache_stall(cache_stall),
    .rd_check_addr(rd_check_addr), .rd_hazard(rd_hazard), .queue_count(queue_count)
  );

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } entry_t;

  entry_t  mq[$];     // model of queue contents, oldest first
  entry_t  exp_q[$];  // writes the model has issued, awaiting the monitor
  int      rr = 0;
  logic    exp_cw = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;
  int      n_checks = 0;
  int      n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[p] = 1'b1;
    req_addr[p*AW +: AW] = a;
    req_data[p*DW +: DW] = d;
  endtask

  // One clock: check combinational outputs, advance the model at the edge, check
  // registered outputs, then complete granted requests and optionally raise new ones.
  task automatic step(input int new_pct);
    int g;
    logic [3:0] exp_ready;
    logic exp_haz;
    #1;
    g = -1;
    if (reset || mq.size() < DEPTH)
      for (int k = 0; k < 4; k++)
        if (g < 0 && req_valid[(rr + k) % 4]) g = (rr + k) % 4;
    exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    exp_haz = 1'b0;
    if (!reset) foreach (mq[j]) if (mq[j].a == rd_check_addr) exp_haz = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("rd_hazard", 64'(rd_hazard), 64'(exp_haz));
    @(posedge clk);
    if (reset) begin
      mq.delete();
      rr = 0;
      exp_cw = 1'b0;
      exp_addr = '0;
      exp_data = '0;
    end else begin
      exp_cw = (mq.size() > 0) && !cache_stall;
      if (exp_cw) begin
        entry_t e;
        e = mq.pop_front();
        exp_addr = e.a;
        exp_data = e.d;
        exp_q.push_back(e);
      end
      if (g >= 0) begin
        entry_t n;
        n.a = req_addr[g*AW +: AW];
        n.d = req_data[g*DW +: DW];
        mq.push_back(n);
        rr = (g + 1) % 4;
      end
    end
    @(negedge clk);
    check("queue_count", 64'(queue_count), 64'(mq.size()));
    check("cache_write", 64'(cache_write), 64'(exp_cw));
    check("cw_addr_reg", 64'(cache_write_addr), 64'(exp_addr));
    check("cw_data_reg", 64'(cache_write_data), 64'(exp_data));
    if (g >= 0 && !reset) req_valid[g] = 1'b0;
    for (int p = 0; p < 4; p++)
      if (!req_valid[p] && $urandom_range(99) < new_pct)
        set_req(p, AW'($urandom_range(15)), $urandom);
  endtask

  // Scoreboard: every issued write must match the oldest model-issued write.
  always @(negedge clk) begin
    if (cache_write === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_write", 64'(cache_write_addr), 64'hFFFF);
      else begin
        entry_t e;
        e = exp_q.pop_front();
        check("sb_addr", 64'(cache_write_addr), 64'(e.a));
        check("sb_data", 64'(cache_write_data), 64'(e.d));
      end
    end
  end

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) step(0);
    reset = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    cache_stall = 1'b0;
    rd_check_addr = '0;
    @(negedge clk);
    do_reset(2);

    // Single write from South.
    set_req(1, 8'h12, 32'hA5A5A5A5);
    idle(4);

    // Fairness: all four ports continuously valid from rr_ptr = 0.
    do_reset(1);
    for (int p = 0; p < 4; p++) set_req(p, AW'(p), DW'(32'h100 + p));
    for (int i = 0; i < 8; i++) step(100);
    req_valid = '0;
    idle(6);

    // Full queue under stall, then drain.
    do_reset(1);
    cache_stall = 1'b1;
    for (int p = 0; p < 4; p++) set_req(p, AW'(8'h20 + p), $urandom);
    idle(4);
    for (int p = 0; p < 4; p++) set_req(p, AW'(8'h30 + p), $urandom);
    idle(2);
    cache_stall = 1'b0;
    idle(8);

    // Hazard against a stalled write to 0x40.
    do_reset(1);
    cache_stall = 1'b1;
    set_req(0, 8'h40, 32'hDEADBEEF);
    step(0);
    rd_check_addr = 8'h40;
    idle(2);
    cache_stall = 1'b0;
    idle(3);

    // Wrap-around: ten sequential writes with alternating stall.
    for (int w = 0; w < 10; w++) begin
      int budget;
      set_req(w % 4, AW'(8'h50 + w), DW'(32'hC0DE_0000 + w));
      budget = 0;
      while (req_valid[w % 4] && budget < 20) begin
        cache_stall = ~cache_stall;
        step(0);
        budget++;
      end
      if (req_valid[w % 4]) check("wrap_accept_timeout", 64'(budget), 64'(0));
    end
    cache_stall = 1'b0;
    idle(6);

    // Reset mid-operation with three queued entries.
    cache_stall = 1'b1;
    for (int p = 0; p < 3; p++) set_req(p, AW'(8'h60 + p), $urandom);
    idle(3);
    do_reset(1);
    cache_stall = 1'b0;
    idle(3);
    for (int p = 0; p < 4; p++) set_req(p, AW'(8'h70 + p), $urandom);
    idle(8);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      cache_stall = ($urandom_range(2) == 0);
      rd_check_addr = AW'($urandom_range(15));
      reset = ($urandom_range(99) < 2);
      step(40);
    end
    reset = 1'b0;
    cache_stall = 1'b0;
    req_valid = '0;
    idle(8);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
